// File: rtl/tile_fb_pkg.sv
// Shared constants, types and tile address helper for the tile framebuffer scheduler.
package tile_fb_pkg;

    localparam int HPIXELS = 640;
    localparam int VPIXELS = 480;
    localparam int TILE    = 20;
    localparam int HBLK    = 32;
    localparam int VBLK    = 24;
    localparam int SIZE    = HBLK * VBLK;

    localparam logic [7:0] BLK = 8'h00;
    localparam logic [7:0] WHT = 8'hFF;
    localparam logic [7:0] RED = 8'hE0;
    localparam logic [7:0] BLU = 8'h03;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } tile_wr_t;

    typedef enum logic [1:0] {S_DISP, S_BLANK, S_CLEAR} fb_state_e;

    // Tile index of the pixel at (hc, vc); only meaningful inside the active area.
    function automatic logic [9:0] tile_index(input logic [9:0] hc, input logic [9:0] vc);
        return (vc / 10'(TILE)) * 10'(HBLK) + hc / 10'(TILE);
    endfunction

endpackage

// File: rtl/tile_wr_fifo.sv
// Host write queue: synchronous FIFO of tile_wr_t, show-ahead head, async active-low reset.
module tile_wr_fifo
    import tile_fb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  tile_wr_t din,
    input  logic     pop,
    output tile_wr_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    tile_wr_t       mem [DEPTH];
    logic [AW:0]    wp;
    logic [AW:0]    rp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full)  wp <= wp + 1'b1;
            if (pop  && !empty) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end

    // Extra pointer bit separates full from empty when the indices match.
    assign dout  = mem[rp[AW-1:0]];
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

endmodule

// File: rtl/tile_fb_scheduler.sv
// Tile framebuffer arbiter: display reads own the RAM in active video, host queue drains in blanking.
// Optional VBLANK_CLEAR_EN: fill the whole framebuffer with CLEAR_COLOR after every frame.
module tile_fb_scheduler
    import tile_fb_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        wr_valid,
    input  logic [9:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        wr_err,
    output logic [9:0]  ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  pix_color,
    output logic [23:0] frame
);

    logic      active;
    logic      frame_tick;
    logic      rdy_q;
    logic      vld_q;
    logic      push;
    logic      pop;
    logic      full;
    logic      empty;
    logic [9:0] rd_addr;
    tile_wr_t  wr_ent;
    tile_wr_t  head;
    fb_state_e state;
    fb_state_e state_nxt;
    fb_state_e mode;

    assign active     = (hc < 10'(HPIXELS)) && (vc < 10'(VPIXELS));
    assign frame_tick = (hc == 10'(HPIXELS - 1)) && (vc == 10'(VPIXELS - 1));
    assign rd_addr    = tile_index(hc, vc);
    assign wr_ready   = rdy_q && !full;
    assign push       = wr_valid && wr_ready;
    assign wr_ent     = '{addr: wr_addr, data: wr_data};

    tile_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (wr_ent),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

`ifdef VBLANK_CLEAR_EN
    logic [9:0] clr_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                clr_addr <= '0;
        else if (frame_tick)       clr_addr <= '0;
        else if (mode == S_CLEAR)  clr_addr <= clr_addr + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_BLANK;
            rdy_q     <= 1'b0;
            vld_q     <= 1'b0;
            pix_color <= '0;
            frame     <= '0;
        end else begin
            state     <= state_nxt;
            rdy_q     <= 1'b1;
            vld_q     <= active;
            pix_color <= vld_q ? ram_rdata : '0;
            if (frame_tick) frame <= frame + 24'd1;
        end
    end

    // Active video overrides the registered state so a blanking write can never leak into it.
    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        wr_err    = 1'b0;
        pop       = 1'b0;
        mode      = active ? S_DISP : ((state == S_CLEAR) ? S_CLEAR : S_BLANK);
        unique case (mode)
            S_DISP: begin
                ram_addr = rd_addr;
                if (state != S_CLEAR) state_nxt = S_DISP;
`ifdef VBLANK_CLEAR_EN
                if (frame_tick) state_nxt = S_CLEAR;
`endif
            end
            S_BLANK: begin
                state_nxt = S_BLANK;
                if (!empty) begin
                    pop       = 1'b1;
                    ram_addr  = head.addr;
                    ram_wdata = head.data;
                    if (head.addr < 10'(SIZE)) ram_we = 1'b1;
                    else                       wr_err = 1'b1;
                end
            end
            S_CLEAR: begin
                ram_wdata = CLEAR_COLOR;
`ifdef VBLANK_CLEAR_EN
                ram_we   = 1'b1;
                ram_addr = clr_addr;
                if (clr_addr == 10'(SIZE - 1)) state_nxt = S_BLANK;
`else
                state_nxt = S_BLANK;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tile_fb_scheduler.sv
// Randomized self-checking bench for tile_fb_scheduler with a queue/array reference model and RAM model.
module tb_tile_fb_scheduler;
    import tile_fb_pkg::*;

    localparam int         DEPTH = 8;
    localparam logic [7:0] CLR   = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hc, vc;
    logic        wr_valid;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready, wr_err, ram_we;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_wdata, ram_rdata, pix_color;
    logic [23:0] frame;

    always #5 clk = ~clk;

    tile_fb_scheduler #(.FIFO_DEPTH(DEPTH), .CLEAR_COLOR(CLR)) dut (
        .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_err(wr_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .pix_color(pix_color), .frame(frame)
    );

    // RAM contents seen by the DUT, and the model's idea of what they should be
    logic [7:0]  mem    [768];
    logic [7:0]  shadow [768];
    tile_wr_t    q[$];
    logic [7:0]  rd_pend, pipe0, pipe1;
    logic [23:0] exp_frame;
    bit          up, clearing;
    int          clr_idx;
    int          n_vec, n_err, wr_seen;
    logic        obs_we, obs_err, obs_rdy;
    logic [9:0]  obs_addr;
    logic [7:0]  obs_pix, obs_wd;
    logic [23:0] obs_frame;

    task automatic step(input logic [9:0] h, input logic [9:0] v, input logic val,
                        input logic [9:0] a, input logic [7:0] d);
        bit         act, rdy, exp_we, exp_err;
        logic [9:0] idx, exp_addr;
        logic [7:0] exp_wd;
        tile_wr_t   e;
        @(negedge clk);
        ram_rdata = rd_pend;
        hc = h; vc = v; wr_valid = val; wr_addr = a; wr_data = d;
        #1;
        act      = (int'(h) < 640) && (int'(v) < 480);
        idx      = 10'((int'(v) / 20) * 32 + int'(h) / 20);
        rdy      = up && (q.size() < DEPTH);
        exp_we   = 1'b0; exp_err = 1'b0; exp_addr = '0; exp_wd = '0;
        if (act) begin
            exp_addr = idx;
        end else if (clearing) begin
            exp_we = 1'b1; exp_addr = 10'(clr_idx); exp_wd = CLR;
            shadow[clr_idx] = CLR;
            clr_idx++;
            if (clr_idx == 768) clearing = 1'b0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            exp_addr = e.addr;
            if (int'(e.addr) < 768) begin
                exp_we = 1'b1; exp_wd = e.data; shadow[e.addr] = e.data;
            end else begin
                exp_err = 1'b1;
            end
        end
        n_vec++;
        if (ram_we !== exp_we) begin
            n_err++; $display("FAIL ram_we hc=%0d vc=%0d: got %b want %b", h, v, ram_we, exp_we);
        end
        n_vec++;
        if (wr_err !== exp_err) begin
            n_err++; $display("FAIL wr_err hc=%0d vc=%0d: got %b want %b", h, v, wr_err, exp_err);
        end
        if (act || exp_we) begin
            n_vec++;
            if (ram_addr !== exp_addr) begin
                n_err++; $display("FAIL ram_addr hc=%0d vc=%0d: got %0d want %0d", h, v, ram_addr, exp_addr);
            end
        end
        if (exp_we) begin
            n_vec++;
            if (ram_wdata !== exp_wd) begin
                n_err++; $display("FAIL ram_wdata hc=%0d vc=%0d: got %h want %h", h, v, ram_wdata, exp_wd);
            end
        end
        n_vec++;
        if (wr_ready !== rdy) begin
            n_err++; $display("FAIL wr_ready hc=%0d vc=%0d: got %b want %b", h, v, wr_ready, rdy);
        end
        n_vec++;
        if (pix_color !== pipe1) begin
            n_err++; $display("FAIL pix_color hc=%0d vc=%0d: got %h want %h", h, v, pix_color, pipe1);
        end
        n_vec++;
        if (frame !== exp_frame) begin
            n_err++; $display("FAIL frame hc=%0d vc=%0d: got %0h want %0h", h, v, frame, exp_frame);
        end
        obs_we = ram_we; obs_err = wr_err; obs_rdy = wr_ready; obs_addr = ram_addr;
        obs_pix = pix_color; obs_wd = ram_wdata; obs_frame = frame;
        if (ram_we === 1'b1) wr_seen++;
        // model state advance for this clock
        if (val && rdy) q.push_back('{addr: a, data: d});
        pipe1 = pipe0;
        pipe0 = act ? shadow[idx] : 8'h00;
        if (int'(h) == 639 && int'(v) == 479) begin
            exp_frame = exp_frame + 24'd1;
`ifdef VBLANK_CLEAR_EN
            clearing = 1'b1; clr_idx = 0;
`endif
        end
        rd_pend = (int'(ram_addr) < 768) ? mem[ram_addr] : 8'h00;
        if (ram_we === 1'b1 && int'(ram_addr) < 768) mem[ram_addr] = ram_wdata;
    endtask

    task automatic run_line(input int v);
        for (int h = 0; h < 800; h++) step(10'(h), 10'(v), 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; hc = 10'd700; vc = 10'd500; wr_valid = 1'b0; ram_rdata = rd_pend;
        #1;
        n_vec++; if (wr_ready !== 1'b0)  begin n_err++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
        n_vec++; if (ram_we !== 1'b0)    begin n_err++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
        n_vec++; if (ram_addr !== 10'd0) begin n_err++; $display("FAIL rst_ram_addr: got %0d want 0", ram_addr); end
        n_vec++; if (wr_err !== 1'b0)    begin n_err++; $display("FAIL rst_wr_err: got %b want 0", wr_err); end
        n_vec++; if (pix_color !== 8'h0) begin n_err++; $display("FAIL rst_pix: got %h want 0", pix_color); end
        n_vec++; if (frame !== 24'h0)    begin n_err++; $display("FAIL rst_frame: got %0h want 0", frame); end
        q.delete(); pipe0 = '0; pipe1 = '0; exp_frame = '0; clearing = 1'b0; clr_idx = 0; up = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; up = 1'b1; rd_pend = mem[0];
    endtask

    task automatic test_idle_frames();
        for (int f = 0; f < 2; f++) begin
            run_line(0); run_line(239); run_line(479); run_line(500);
        end
        n_vec++;
        if (frame !== 24'd2) begin n_err++; $display("FAIL idle_frame_count: got %0d want 2", frame); end
    endtask

    task automatic test_single_write();
        for (int h = 0; h < 800; h++) begin
            step(10'(h), 10'd10, h == 100, 10'd5, RED);
            if (h == 640) begin
                n_vec++;
                if (obs_we !== 1'b1 || obs_addr !== 10'd5) begin
                    n_err++; $display("FAIL tile5_write: we=%b addr=%0d want we=1 addr=5", obs_we, obs_addr);
                end
            end
        end
        for (int h = 0; h < 800; h++) begin
            step(10'(h), 10'd10, 1'b0, '0, '0);
            if (h == 102) begin
                n_vec++;
                if (obs_pix !== RED) begin n_err++; $display("FAIL tile5_pix: got %h want e0", obs_pix); end
            end
        end
    endtask

    task automatic test_back_to_back();
        wr_seen = 0;
        for (int h = 0; h < 800; h++) begin
            step(10'(h), 10'd100, h < DEPTH + 1, 10'(200 + 7 * h), 8'($urandom));
            if (h == DEPTH - 1 || h == DEPTH) begin
                n_vec++;
                if (obs_rdy !== (h == DEPTH - 1)) begin
                    n_err++; $display("FAIL fill_ready h=%0d: got %b want %b", h, obs_rdy, h == DEPTH - 1);
                end
            end
        end
        n_vec++;
        if (wr_seen != DEPTH) begin n_err++; $display("FAIL fill_write_count: got %0d want %0d", wr_seen, DEPTH); end
    endtask

    task automatic test_bad_addr();
        for (int h = 0; h < 800; h++) begin
            step(10'(h), 10'd101, h < 2, (h == 0) ? 10'd800 : 10'd7, 8'h1C);
            if (h == 640) begin
                n_vec++;
                if (obs_err !== 1'b1 || obs_we !== 1'b0) begin
                    n_err++; $display("FAIL bad_addr_drop: err=%b we=%b want err=1 we=0", obs_err, obs_we);
                end
            end
            if (h == 641) begin
                n_vec++;
                if (obs_we !== 1'b1 || obs_addr !== 10'd7 || obs_err !== 1'b0) begin
                    n_err++; $display("FAIL bad_addr_next: we=%b addr=%0d err=%b want 1/7/0", obs_we, obs_addr, obs_err);
                end
            end
        end
    endtask

    task automatic test_random();
        int v;
        for (int l = 0; l < 10; l++) begin
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(480, 524) : $urandom_range(0, 478);
            for (int h = 0; h < 800; h++)
                step(10'(h), 10'(v), $urandom_range(0, 9) < 3, 10'($urandom_range(0, 799)), 8'($urandom));
        end
    endtask

    task automatic test_reset_mid_drain();
        run_line(500);
        for (int h = 0; h < 642; h++) step(10'(h), 10'd102, h < 4, 10'(300 + h), 8'($urandom));
        test_reset();
        wr_seen = 0;
        run_line(103);
        n_vec++;
        if (wr_seen != 0) begin n_err++; $display("FAIL reset_drop: got %0d writes want 0", wr_seen); end
    endtask

    task automatic test_frame_wrap();
        force dut.frame = 24'hFFFFFF;
        #1;
        release dut.frame;
        exp_frame = 24'hFFFFFF;
        for (int h = 0; h < 800; h++) begin
            step(10'(h), 10'd479, 1'b0, '0, '0);
            if (h == 640) begin
                n_vec++;
                if (obs_frame !== 24'h0) begin n_err++; $display("FAIL frame_wrap: got %0h want 0", obs_frame); end
            end
        end
        run_line(500);
    endtask

`ifdef VBLANK_CLEAR_EN
    task automatic test_clear();
        int at;
        for (int h = 0; h < 800; h++) step(10'(h), 10'd200, h == 0, 10'd100, WHT);
        wr_seen = 0; at = -1;
        for (int h = 0; h < 800; h++) begin
            step(10'(h), 10'd479, h == 700, 10'd3, 8'hAA);
            if (obs_we === 1'b1 && obs_addr === 10'd3 && obs_wd === 8'hAA) at = wr_seen;
        end
        for (int h = 0; h < 800; h++) begin
            step(10'(h), 10'd500, 1'b0, '0, '0);
            if (obs_we === 1'b1 && obs_addr === 10'd3 && obs_wd === 8'hAA) at = wr_seen;
        end
        n_vec++;
        if (at != 769) begin n_err++; $display("FAIL clear_host_order: host write was #%0d want 769", at); end
    endtask
`endif

    initial begin
        n_vec = 0; n_err = 0; wr_seen = 0;
        rst_n = 1'b0; hc = 10'd700; vc = 10'd500; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        ram_rdata = '0; rd_pend = '0; pipe0 = '0; pipe1 = '0; exp_frame = '0;
        up = 1'b0; clearing = 1'b0; clr_idx = 0;
        for (int i = 0; i < 768; i++) begin mem[i] = 8'h00; shadow[i] = 8'h00; end
        test_reset();
        test_idle_frames();
        test_single_write();
        test_back_to_back();
        test_bad_addr();
        test_random();
        test_reset_mid_drain();
        test_frame_wrap();
`ifdef VBLANK_CLEAR_EN
        test_clear();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
